// File: rtl/mem_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_read_arbiter: round-robin sharing of the mem_control read port with    |
// | credit limit and an outstanding table that routes responses back to owners |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_read_arbiter #(
  parameter int N      = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  input  logic [N*ADDR_W-1:0]        req_addr,
  output logic [N-1:0]               req_ready,
  output logic [N-1:0]               resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [ADDR_W-1:0]          resp_addr,
  output logic                       mem_read_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_flag,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic [ADDR_W-1:0]          mem_ret_addr,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_unmatched
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int EW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
  logic [IDW-1:0]    ent_id_q   [DEPTH];
  logic [IDW-1:0]    ent_id_d   [DEPTH];
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0]      resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic              err_unmatched_q, err_unmatched_d;

  logic           slot_free, win_found, free_found, match_found, xfer, resp_hit;
  logic [IDW-1:0] win_id, cand;
  logic [EW-1:0]  free_idx, match_idx;

  // Winner search starts just after the last granted requester.
  always_comb begin
    slot_free   = (outstanding_q < CW'(DEPTH));
    win_found   = 1'b0;
    win_id      = '0;
    cand        = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_found && !ent_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = EW'(i);
      end
      if (!match_found && ent_valid_q[i] && (ent_addr_q[i] == mem_ret_addr)) begin
        match_found = 1'b1;
        match_idx   = EW'(i);
      end
    end
    xfer      = slot_free && win_found;
    resp_hit  = mem_flag && match_found;
    req_ready = '0;
    if (xfer) req_ready[win_id] = 1'b1;
  end

  // Free and allocate both look at pre-edge state, so a freed entry is never reused the same cycle.
  always_comb begin
    ent_valid_d     = ent_valid_q;
    ent_id_d        = ent_id_q;
    ent_addr_d      = ent_addr_q;
    ptr_d           = ptr_q;
    mem_read_en_d   = xfer;
    mem_addr_d      = mem_addr_q;
    resp_valid_d    = '0;
    resp_data_d     = resp_data_q;
    resp_addr_d     = resp_addr_q;
    err_unmatched_d = mem_flag && !match_found;
    outstanding_d   = outstanding_q + CW'(xfer) - CW'(resp_hit);
    if (resp_hit) begin
      ent_valid_d[match_idx]         = 1'b0;
      resp_valid_d[ent_id_q[match_idx]] = 1'b1;
      resp_data_d                    = mem_data;
      resp_addr_d                    = mem_ret_addr;
    end
    if (xfer) begin
      ent_valid_d[free_idx] = 1'b1;
      ent_id_d[free_idx]    = win_id;
      ent_addr_d[free_idx]  = addr_arr[win_id];
      ptr_d                 = win_id;
      mem_addr_d            = addr_arr[win_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_id_q[i]   <= '0;
        ent_addr_q[i] <= '0;
      end
      ptr_q           <= IDW'(N - 1);
      outstanding_q   <= '0;
      mem_read_en_q   <= 1'b0;
      mem_addr_q      <= '0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      resp_addr_q     <= '0;
      err_unmatched_q <= 1'b0;
    end else begin
      ent_valid_q     <= ent_valid_d;
      ent_id_q        <= ent_id_d;
      ent_addr_q      <= ent_addr_d;
      ptr_q           <= ptr_d;
      outstanding_q   <= outstanding_d;
      mem_read_en_q   <= mem_read_en_d;
      mem_addr_q      <= mem_addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_addr_q     <= resp_addr_d;
      err_unmatched_q <= err_unmatched_d;
    end
  end

  assign outstanding   = outstanding_q;
  assign mem_read_en   = mem_read_en_q;
  assign mem_addr      = mem_addr_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_addr     = resp_addr_q;
  assign err_unmatched = err_unmatched_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_read_arbiter: per-cycle vector table with issue/response queues     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_data;
  logic [7:0]  resp_addr;
  logic        mem_read_en;
  logic [7:0]  mem_addr;
  logic        mem_flag;
  logic [7:0]  mem_data;
  logic [7:0]  mem_ret_addr;
  logic [2:0]  outstanding;
  logic        err_unmatched;

  always #5 clk = ~clk;

  mem_read_arbiter #(.N(4), .ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_flag(mem_flag), .mem_data(mem_data), .mem_ret_addr(mem_ret_addr),
    .outstanding(outstanding), .err_unmatched(err_unmatched)
  );

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [7:0] addr;
  } resp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] addrs;
    logic        flag;
    logic [7:0]  data;
    logic [7:0]  raddr;
    int          resp_id;
    logic [3:0]  exp_ready;
    int          exp_out;
    logic        chk_zero;
  } vec_t;

  resp_t      resp_q[$];
  logic [7:0] iss_q[$];
  vec_t       vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] a,
                              input logic f, input logic [7:0] d, input logic [7:0] ra,
                              input int rid, input logic [3:0] er, input int eo,
                              input logic cz);
    vec_t t;
    t.rst = r; t.valid = v; t.addrs = a; t.flag = f; t.data = d; t.raddr = ra;
    t.resp_id = rid; t.exp_ready = er; t.exp_out = eo; t.chk_zero = cz;
    return t;
  endfunction

  // Every queued expectation must be met exactly one edge after it was queued.
  initial begin : monitor
    logic       exp_en;
    logic [7:0] exp_a;
    resp_t      r;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        exp_en = (iss_q.size() > 0);
        exp_a  = exp_en ? iss_q.pop_front() : 8'h00;
        chk("mem_read_en", {31'b0, mem_read_en}, {31'b0, exp_en});
        if (exp_en) chk("mem_addr", {24'b0, mem_addr}, {24'b0, exp_a});
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          chk("resp_valid", {28'b0, resp_valid}, (r.id >= 0) ? (32'd1 << r.id) : 32'd0);
          chk("err_unmatched", {31'b0, err_unmatched}, {31'b0, (r.id < 0)});
          if (r.id >= 0) begin
            chk("resp_data", {24'b0, resp_data}, {24'b0, r.data});
            chk("resp_addr", {24'b0, resp_addr}, {24'b0, r.addr});
          end
        end else begin
          chk("resp_valid_idle", {28'b0, resp_valid}, 32'd0);
          chk("err_unmatched_idle", {31'b0, err_unmatched}, 32'd0);
        end
      end
    end
  end

  initial begin : main
    vec_t cur;
    rst = 1'b1; req_valid = '0; req_addr = '0;
    mem_flag = 1'b0; mem_data = '0; mem_ret_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {28'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", {24'b0, resp_data}, 32'd0);
    chk("rst_resp_addr", {24'b0, resp_addr}, 32'd0);
    chk("rst_mem_read_en", {31'b0, mem_read_en}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_outstanding", {29'b0, outstanding}, 32'd0);
    chk("rst_err_unmatched", {31'b0, err_unmatched}, 32'd0);
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    mon_en = 1'b1;

    // single request round trip
    vecs.push_back(mk(0, 4'b0001, 32'h00000002, 0, 0,  0, 0, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000002, 0, 0,  0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000002, 1, 69, 2, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000002, 0, 0,  0, 0, 4'b0000, 0, 0));
    // reset, then all four held: grants 0..3, credit stall, full + simultaneous response
    vecs.push_back(mk(1, 4'b0000, 32'h020F0600, 0, 0,  0,  0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b0001, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b1000, 3, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b0000, 4, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 1, 17, 15, 2, 4'b0000, 4, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h020F0600, 0, 0,  0,  0, 4'b0001, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h020F0600, 1, 99, 6,  1, 4'b0000, 4, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h020F0600, 1, 5,  0,  0, 4'b0000, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h020F0600, 1, 5,  0,  0, 4'b0000, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h020F0600, 1, 69, 2,  3, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h020F0600, 0, 0,  0,  0, 4'b0000, 0, 0));
    // out-of-order return
    vecs.push_back(mk(0, 4'b0010, 32'h00000600, 0, 0,  0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 32'h00000000, 0, 0,  0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 1, 33, 0, 2, 4'b0000, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 1, 99, 6, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h00000000, 0, 0,  0, 0, 4'b0000, 0, 0));
    // duplicate addresses, then an unmatched response
    vecs.push_back(mk(0, 4'b0001, 32'h02000002, 0, 0,  0, 0,  4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 32'h02000002, 0, 0,  0, 0,  4'b1000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h02000002, 1, 69, 2, 0,  4'b0000, 2, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h02000002, 1, 69, 2, 3,  4'b0000, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h02000002, 1, 1,  9, -1, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h02000002, 0, 0,  0, 0,  4'b0000, 0, 0));
    // reset with three in flight; the late response is unmatched
    vecs.push_back(mk(0, 4'b0111, 32'h000F0602, 0, 0,  0, 0,  4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0111, 32'h000F0602, 0, 0,  0, 0,  4'b0010, 1, 0));
    vecs.push_back(mk(0, 4'b0111, 32'h000F0602, 0, 0,  0, 0,  4'b0100, 2, 0));
    vecs.push_back(mk(1, 4'b0000, 32'h000F0602, 0, 0,  0, 0,  4'b0000, 3, 0));
    vecs.push_back(mk(0, 4'b0000, 32'h000F0602, 1, 69, 2, -1, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 32'h000F0602, 0, 0,  0, 0,  4'b0000, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      cur = vecs[n];
      @(negedge clk);
      rst = cur.rst; req_valid = cur.valid; req_addr = cur.addrs;
      mem_flag = cur.flag; mem_data = cur.data; mem_ret_addr = cur.raddr;
      #1;
      chk($sformatf("req_ready[v%0d]", n), {28'b0, req_ready}, {28'b0, cur.exp_ready});
      chk($sformatf("outstanding[v%0d]", n), {29'b0, outstanding}, cur.exp_out);
      if (cur.chk_zero) begin
        chk($sformatf("post_rst_mem_addr[v%0d]", n), {24'b0, mem_addr}, 32'd0);
        chk($sformatf("post_rst_resp_data[v%0d]", n), {24'b0, resp_data}, 32'd0);
        chk($sformatf("post_rst_resp_addr[v%0d]", n), {24'b0, resp_addr}, 32'd0);
      end
      if (!cur.rst) begin
        for (int w = 0; w < 4; w++)
          if (cur.exp_ready[w]) iss_q.push_back(cur.addrs[w*8 +: 8]);
        if (cur.flag) resp_q.push_back('{id: cur.resp_id, data: cur.data, addr: cur.raddr});
      end
    end

    @(negedge clk);
    rst = 1'b0; req_valid = '0; mem_flag = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", iss_q.size() + resp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
